// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: clock-mode constants and the
// two-state transfer encoding.
package spi_slave_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into wb_clk and produces single-cycle
// edge pulses for sck and ss.
module spi_slave_sync #(
    parameter logic CPOL        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic sck_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise
);

    logic [SYNC_STAGES-1:0] sck_ff;
    logic [SYNC_STAGES-1:0] ss_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sck_prev_reg;
    logic                   ss_prev_reg;
    logic                   sck_s;
    logic                   ss_s;

    // Reset values match idle pins so leaving reset never fakes an edge.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge wb_clk) begin
                if (wb_rst) begin
                    sck_ff[gi]  <= CPOL;
                    ss_ff[gi]   <= 1'b1;
                    mosi_ff[gi] <= 1'b0;
                end else begin
                    sck_ff[gi]  <= sck_i;
                    ss_ff[gi]   <= ss_i;
                    mosi_ff[gi] <= mosi_i;
                end
            end
        end else begin : g_next
            always_ff @(posedge wb_clk) begin
                if (wb_rst) begin
                    sck_ff[gi]  <= CPOL;
                    ss_ff[gi]   <= 1'b1;
                    mosi_ff[gi] <= 1'b0;
                end else begin
                    sck_ff[gi]  <= sck_ff[gi-1];
                    ss_ff[gi]   <= ss_ff[gi-1];
                    mosi_ff[gi] <= mosi_ff[gi-1];
                end
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sck_prev_reg <= CPOL;
            ss_prev_reg  <= 1'b1;
        end else begin
            sck_prev_reg <= sck_s;
            ss_prev_reg  <= ss_s;
        end
    end

    assign sck_s    = sck_ff[SYNC_STAGES-1];
    assign ss_s     = ss_ff[SYNC_STAGES-1];
    assign mosi_s   = mosi_ff[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign ss_fall  = ~ss_s & ss_prev_reg;
    assign ss_rise  = ss_s & ~ss_prev_reg;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI responder: 8-bit MSB-first frames, one-byte transmit
// holding register with valid/ready, received bytes on a one-cycle strobe.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic       CPOL        = 1'b0,
    parameter logic       CPHA        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       sck_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    spi_state_t state_reg;
    logic [2:0] bitcnt_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic [7:0] tx_byte_reg;
    logic [7:0] hold_reg;
    logic       hold_full_reg;
    logic       underrun_reg;
    logic       miso_reg;
    logic       miso_oe_reg;

    logic mosi_s, sck_rise, sck_fall, ss_fall, ss_rise;
    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic in_shift, start, last_sample, load, accept;
    logic [7:0] next_byte;

    spi_slave_sync #(
        .CPOL        (CPOL),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .sck_i    (sck_i),
        .ss_i     (ss_i),
        .mosi_i   (mosi_i),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise)
    );

    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;

    assign in_shift    = (state_reg == ST_SHIFT);
    assign start       = !in_shift && ss_fall;
    assign last_sample = in_shift && sample_edge && (bitcnt_reg == 3'd7);
    assign load        = start || last_sample;
    assign next_byte   = hold_full_reg ? hold_reg : DEFAULT_TX;
    assign accept      = tx_valid && !hold_full_reg;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_reg     <= ST_IDLE;
            bitcnt_reg    <= 3'd0;
            rx_shift_reg  <= 8'h00;
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            tx_byte_reg   <= DEFAULT_TX;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            miso_reg      <= DEFAULT_TX[7];
            miso_oe_reg   <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;

            // A load never bypasses the holding register; an offer accepted
            // in the same cycle is kept for the following byte.
            if (load) begin
                tx_byte_reg <= next_byte;
                if (hold_full_reg) begin
                    hold_full_reg <= 1'b0;
                end else begin
                    underrun_reg <= 1'b1;
                end
                if (!CPHA) begin
                    miso_reg <= next_byte[7];
                end
            end
            if (accept) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_reg   <= ST_SHIFT;
                        bitcnt_reg  <= 3'd0;
                        miso_oe_reg <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
                        bitcnt_reg   <= bitcnt_reg + 3'd1;
                        if (bitcnt_reg == 3'd7) begin
                            rx_data_reg  <= {rx_shift_reg[6:0], mosi_s};
                            rx_valid_reg <= 1'b1;
                        end
                    end
                    if (drive_edge && (CPHA || (bitcnt_reg != 3'd0))) begin
                        miso_reg <= tx_byte_reg[3'd7 - bitcnt_reg];
                    end
                    // Deselect wins last so a byte completing now still strobes.
                    if (ss_rise) begin
                        state_reg   <= ST_IDLE;
                        bitcnt_reg  <= 3'd0;
                        miso_oe_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign miso_o      = miso_reg;
    assign miso_oe     = miso_oe_reg;
    assign tx_ready    = !hold_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_underrun = underrun_reg;
    assign busy        = in_shift;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: three instances (modes 0, 1 and 3) driven by a
// bit-banged master with hand-computed expectations.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam logic [2:0] CPOL_V = {MODE3.cpol, MODE1.cpol, MODE0.cpol};
    localparam logic [2:0] CPHA_V = {MODE3.cpha, MODE1.cpha, MODE0.cpha};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sck, ss, mosi, miso, miso_oe, tx_valid, tx_ready;
    logic [2:0] rx_valid, tx_underrun, busy;
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];

    int         n_vec = 0;
    int         n_bad = 0;
    int         rxv_cnt [3] = '{0, 0, 0};
    int         unr_cnt [3] = '{0, 0, 0};
    logic [7:0] rx_last [3] = '{8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    spi_slave #(.CPOL(MODE0.cpol), .CPHA(MODE0.cpha)) u_m0 (
        .wb_clk(clk), .wb_rst(rst), .sck_i(sck[0]), .ss_i(ss[0]), .mosi_i(mosi[0]),
        .miso_o(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .tx_underrun(tx_underrun[0]), .busy(busy[0]));

    spi_slave #(.CPOL(MODE1.cpol), .CPHA(MODE1.cpha)) u_m1 (
        .wb_clk(clk), .wb_rst(rst), .sck_i(sck[1]), .ss_i(ss[1]), .mosi_i(mosi[1]),
        .miso_o(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .tx_underrun(tx_underrun[1]), .busy(busy[1]));

    spi_slave #(.CPOL(MODE3.cpol), .CPHA(MODE3.cpha)) u_m3 (
        .wb_clk(clk), .wb_rst(rst), .sck_i(sck[2]), .ss_i(ss[2]), .mosi_i(mosi[2]),
        .miso_o(miso[2]), .miso_oe(miso_oe[2]), .tx_data(tx_data[2]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .rx_data(rx_data[2]),
        .rx_valid(rx_valid[2]), .tx_underrun(tx_underrun[2]), .busy(busy[2]));

    // Strobe monitors: count pulses and capture each received byte.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rx_valid[k]) begin
                rxv_cnt[k] <= rxv_cnt[k] + 1;
                rx_last[k] <= rx_data[k];
            end
            if (tx_underrun[k]) unr_cnt[k] <= unr_cnt[k] + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic offer(input int m, input logic [7:0] d);
        int t;
        t = 0;
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        while (!tx_ready[m] && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_value($sformatf("offer_ready_m%0d", m), tx_ready[m], 1);
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic ss_low(input int m);
        ss[m] = 1'b0;
        half();
    endtask

    task automatic ss_high(input int m);
        ss[m] = 1'b1;
        half();
        half();
    endtask

    // Master side: drives mosi and captures miso on the opposite sck edge.
    task automatic shift_bits(input int m, input int n, input logic [7:0] b, output logic [7:0] got);
        logic pol, pha;
        pol = CPOL_V[m];
        pha = CPHA_V[m];
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!pha) mosi[m] = b[7-i];
            half();
            sck[m] = ~pol;
            if (!pha) got[7-i] = miso[m];
            else      mosi[m] = b[7-i];
            half();
            sck[m] = pol;
            if (pha) got[7-i] = miso[m];
        end
        half();
        $display("xfer m%0d bits=%0d mosi=%02h miso=%02h", m, n, b, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got, got2;
        int r0, u0;

        rst = 1'b1;
        sck = CPOL_V;
        ss = 3'b111;
        mosi = 3'b000;
        tx_valid = 3'b000;
        for (int k = 0; k < 3; k++) tx_data[k] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            check_value($sformatf("rst_busy_m%0d", k), busy[k], 0);
            check_value($sformatf("rst_oe_m%0d", k), miso_oe[k], 0);
            check_value($sformatf("rst_miso_m%0d", k), miso[k], 1);
            check_value($sformatf("rst_ready_m%0d", k), tx_ready[k], 1);
            check_value($sformatf("rst_rxdata_m%0d", k), rx_data[k], 0);
            check_value($sformatf("rst_strobes_m%0d", k), {rx_valid[k], tx_underrun[k]}, 0);
        end

        // Mode 0, preloaded response.
        offer(0, 8'hA5);
        check_value("t1_ready_low", tx_ready[0], 0);
        r0 = rxv_cnt[0]; u0 = unr_cnt[0];
        ss_low(0);
        check_value("t1_busy", busy[0], 1);
        check_value("t1_oe", miso_oe[0], 1);
        check_value("t1_unr_at_start", unr_cnt[0] - u0, 0);
        shift_bits(0, 8, 8'h3C, got);
        ss_high(0);
        check_value("t1_miso", got, 8'hA5);
        check_value("t1_rx", rx_last[0], 8'h3C);
        check_value("t1_rxv_count", rxv_cnt[0] - r0, 1);
        check_value("t1_ready", tx_ready[0], 1);
        check_value("t1_unr_end_load", unr_cnt[0] - u0, 1);

        // Mode 0, nothing offered.
        r0 = rxv_cnt[0]; u0 = unr_cnt[0];
        ss_low(0);
        check_value("t2_unr_at_start", unr_cnt[0] - u0, 1);
        shift_bits(0, 8, 8'h00, got);
        ss_high(0);
        check_value("t2_miso", got, 8'hFF);
        check_value("t2_rx", rx_last[0], 8'h00);
        check_value("t2_rxv_count", rxv_cnt[0] - r0, 1);

        // Mode 3, three-byte burst with refill on tx_ready.
        offer(2, 8'h10);
        u0 = unr_cnt[2]; r0 = rxv_cnt[2];
        fork
            offer(2, 8'h20);
            begin
                ss_low(2);
                shift_bits(2, 8, 8'h01, got);
                check_value("t3_miso0", got, 8'h10);
                check_value("t3_rx0", rx_last[2], 8'h01);
                check_value("t3_unr0", unr_cnt[2] - u0, 0);
                shift_bits(2, 8, 8'h02, got);
                check_value("t3_miso1", got, 8'h20);
                check_value("t3_rx1", rx_last[2], 8'h02);
                check_value("t3_unr1", unr_cnt[2] - u0, 1);
                shift_bits(2, 8, 8'h03, got);
                check_value("t3_miso2", got, 8'hFF);
                check_value("t3_rx2", rx_last[2], 8'h03);
                ss_high(2);
            end
        join
        check_value("t3_rxv_count", rxv_cnt[2] - r0, 3);

        // Mode 0, abort after 5 bits, then a full frame.
        r0 = rxv_cnt[0];
        ss_low(0);
        shift_bits(0, 5, 8'hF0, got);
        ss[0] = 1'b1;
        half();
        check_value("t4_busy", busy[0], 0);
        check_value("t4_oe", miso_oe[0], 0);
        check_value("t4_no_rxv", rxv_cnt[0] - r0, 0);
        half();
        ss_low(0);
        shift_bits(0, 8, 8'h81, got);
        ss_high(0);
        check_value("t4_rx", rx_last[0], 8'h81);
        check_value("t4_rxv_count", rxv_cnt[0] - r0, 1);

        // Mode 1, offer held while the holding register is full.
        offer(1, 8'h5A);
        u0 = unr_cnt[1];
        tx_data[1]  = 8'hC3;
        tx_valid[1] = 1'b1;
        repeat (4) @(negedge clk);
        check_value("t5_ready_low", tx_ready[1], 0);
        fork
            offer(1, 8'hC3);
            begin
                ss_low(1);
                shift_bits(1, 8, 8'h96, got);
                check_value("t5_rx0", rx_last[1], 8'h96);
                shift_bits(1, 8, 8'h69, got2);
                check_value("t5_rx1", rx_last[1], 8'h69);
                ss_high(1);
            end
        join
        check_value("t5_miso0", got, 8'h5A);
        check_value("t5_miso1", got2, 8'hC3);
        check_value("t5_unr", unr_cnt[1] - u0, 1);

        // Mode 0, reset in the middle of a byte.
        ss_low(0);
        offer(0, 8'h3E);
        shift_bits(0, 4, 8'hB4, got);
        rst = 1'b1;
        ss[0] = 1'b1;
        @(negedge clk);
        check_value("t6_busy", busy[0], 0);
        check_value("t6_oe", miso_oe[0], 0);
        check_value("t6_miso", miso[0], 1);
        check_value("t6_ready", tx_ready[0], 1);
        check_value("t6_rxdata", rx_data[0], 0);
        rst = 1'b0;
        half();
        r0 = rxv_cnt[0];
        offer(0, 8'h77);
        ss_low(0);
        shift_bits(0, 8, 8'hE7, got);
        ss_high(0);
        check_value("t6_miso_after", got, 8'h77);
        check_value("t6_rx_after", rx_last[0], 8'hE7);
        check_value("t6_rxv_count", rxv_cnt[0] - r0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
